regfile_mmio: RTL and testbench
===============================

# regfile_mmio

Parametrised CPU register file with hardware-mapped registers, the successor to the fixed 32x32 game register file. One write port and two read ports serve the processor pipeline. Selected registers are loaded by game hardware every cycle, either as plain snapshots or as sticky event latches cleared by write-1-to-clear. Two "slot" registers are kept mutually exclusive in their low field, and three registers are tapped out to the game logic.

## Interface
Parameters:
- WIDTH, 32, data width of every register.
- ADDR_W, 5, register address width; NREGS = 2**ADDR_W.
- HW_MASK, NREGS'h1CE (regs 1,2,3,6,7,8), bit i=1: register i is hardware-written.
- STICKY_MASK, NREGS'h00C (regs 2,3), subset of HW_MASK: OR-accumulate plus W1C instead of snapshot.
- SLOT_A, 4, first slot register index.
- SLOT_B, 5, second slot register index.
- SLOT_BITS, 4, width of the slot field (bits [SLOT_BITS-1:0]).
- NSLOTS, 9, legal slot values 0..NSLOTS-1; requires NSLOTS <= 2**SLOT_BITS.
- TAP0, 4 / TAP1, 5 / TAP2, 9, register indices driven on tap outputs.

Ports:
- clock  in  1  single clock, all state on rising edge.
- ctrl_reset  in  1  synchronous, active-high reset.
- ctrl_writeEnable  in  1  CPU write strobe.
- ctrl_writeReg  in  ADDR_W  CPU write address.
- data_writeReg  in  WIDTH  CPU write data.
- ctrl_readRegA, ctrl_readRegB  in  ADDR_W  read addresses.
- data_readRegA, data_readRegB  out  WIDTH  combinational read data.
- hw_write  in  NREGS*WIDTH  flat hardware inputs; slice i = [i*WIDTH +: WIDTH], used only where HW_MASK[i]=1.
- tap0, tap1, tap2  out  WIDTH  stored value of registers TAP0/TAP1/TAP2.
- slot_fixup  out  1  registered; 1 for one cycle after a slot write was substituted.

## Operation
- Reset (ctrl_reset=1 at edge): all registers 0, slot_fixup 0; overrides all writes and hardware inputs. Taps and reads show 0 the cycle after reset.
- Register 0: always reads 0, never written.
- Snapshot registers (HW_MASK=1, STICKY_MASK=0): reg <= hw_write slice every cycle. CPU writes are ignored.
- Sticky registers (STICKY_MASK=1):
  - Without a CPU write: reg <= reg | hw.
  - With a CPU write: reg <= (reg & ~data_writeReg) | hw. A set on the same bit in the same cycle beats the clear.
- Slot registers SLOT_A/SLOT_B, on a CPU write with requested field v = data_writeReg[SLOT_BITS-1:0] and peer's current stored field p:
  - Upper bits [WIDTH-1:SLOT_BITS] are always stored as written.
  - If v >= NSLOTS, the field is stored as 0.
  - Else if v != p, v is stored.
  - Else (v == p), the field is stored as (v+1) mod NSLOTS, and slot_fixup is 1 next cycle.
  - Any other cycle: slot_fixup <= 0.
- General registers (all others): reg <= data_writeReg on write.
- Reads:
  - data_readRegX = stored value, except when ctrl_writeEnable=1, ctrl_writeReg == ctrl_readRegX and the target is general or slot. In that case the value that will be stored is forwarded: the raw data for a general register, the resolved field for a slot register.
  - Reads of hardware registers and register 0 never forward.
- Taps never forward; they show stored state only.

## Timing
- Write latency: stored at the same edge; readable the next cycle, or the same cycle via forwarding.
- Hardware inputs are sampled every edge and visible on reads and taps one cycle later.
- Sticky accumulation is per-edge; a 1-cycle pulse is retained until cleared.
- Slot comparison uses the peer's stored field, not a value being written in the same cycle (single write port, so no simultaneous slot writes).
- Reset in the middle of accumulation discards latched events. The first hardware sample after reset is taken at the edge following the deassertion of ctrl_reset.

## Test plan
- Reset, then write 0xDEADBEEF to reg 12 with readRegA=12 -> readA=0xDEADBEEF in the same cycle (forward); next cycle readA=0xDEADBEEF without write; reg 0 write of 5 -> reads 0.
- hw slice 6 = 0x1234 for 1 cycle, then 0 -> reg 6 reads 0x1234 one cycle later, then 0; CPU write 0xFFFF to reg 6 -> ignored.
- Pulse hw slice 2 = 0x1, later 0x4 -> reg 2 = 0x5. Write 0x1 to reg 2 -> 0x4. Write 0x4 while hw bit 2 is high -> stays 0x4.
- Write reg 4 = 0x30 (field 0), then reg 5 = 0x70 -> reg 5 = 0x71 and slot_fixup=1 for one cycle. Write reg 4 = 0x08 while reg 5 field=8 -> 0x00. Write reg 5 = 0x0F -> 0x00.
- Forwarding on slot: write reg 5 = 0x70 with peer field 0 and readRegB=5 -> readB=0x71 in the same cycle; tap1 shows 0x71 only next cycle.
- Assert ctrl_reset while reg 3 holds 0xFF and hw is active -> next cycle all reads, taps and slot_fixup are 0.

Source files
------------

// File: rtl/regfile_mmio.sv
// regfile_mmio: CPU register file (1 write, 2 read ports) with hardware-loaded
// snapshot/sticky registers, a mutually exclusive slot register pair and
// three tap outputs for the game logic.
module regfile_mmio #(
    parameter int WIDTH = 32,
    parameter int ADDR_W = 5,
    parameter logic [(2**ADDR_W)-1:0] HW_MASK = 'h1CE,
    parameter logic [(2**ADDR_W)-1:0] STICKY_MASK = 'h00C,
    parameter int SLOT_A = 4,
    parameter int SLOT_B = 5,
    parameter int SLOT_BITS = 4,
    parameter int NSLOTS = 9,
    parameter int TAP0 = 4,
    parameter int TAP1 = 5,
    parameter int TAP2 = 9
) (
    input  logic                            clock,
    input  logic                            ctrl_reset,
    input  logic                            ctrl_writeEnable,
    input  logic [ADDR_W-1:0]               ctrl_writeReg,
    input  logic [WIDTH-1:0]                data_writeReg,
    input  logic [ADDR_W-1:0]               ctrl_readRegA,
    input  logic [ADDR_W-1:0]               ctrl_readRegB,
    output logic [WIDTH-1:0]                data_readRegA,
    output logic [WIDTH-1:0]                data_readRegB,
    input  logic [(2**ADDR_W)*WIDTH-1:0]    hw_write,
    output logic [WIDTH-1:0]                tap0,
    output logic [WIDTH-1:0]                tap1,
    output logic [WIDTH-1:0]                tap2,
    output logic                            slot_fixup
);

    localparam int NREGS = 2**ADDR_W;
    localparam logic [31:0] NSLOTS_U = NSLOTS;
    localparam logic [31:0] LAST_SLOT = NSLOTS - 1;

    logic [WIDTH-1:0] regs [NREGS];

    logic                 wr_slot;
    logic                 wr_fwd;
    logic [SLOT_BITS-1:0] req_field;
    logic [SLOT_BITS-1:0] peer_field;
    logic [SLOT_BITS-1:0] field_res;
    logic                 collide;
    logic [WIDTH-1:0]     slot_value;
    logic [WIDTH-1:0]     fwd_value;

    assign wr_slot = ctrl_writeEnable &&
                     (ctrl_writeReg == ADDR_W'(SLOT_A) || ctrl_writeReg == ADDR_W'(SLOT_B));

    // Resolve the slot field against the peer's stored field; an out-of-range
    // request parks at 0, a collision bumps to the next legal value.
    always_comb begin
        req_field  = data_writeReg[SLOT_BITS-1:0];
        peer_field = (ctrl_writeReg == ADDR_W'(SLOT_A)) ? regs[SLOT_B][SLOT_BITS-1:0]
                                                         : regs[SLOT_A][SLOT_BITS-1:0];
        collide    = 1'b0;
        field_res  = req_field;
        if (32'(req_field) >= NSLOTS_U) begin
            field_res = '0;
        end else if (req_field == peer_field) begin
            collide   = 1'b1;
            field_res = (32'(req_field) == LAST_SLOT) ? '0 : req_field + SLOT_BITS'(1);
        end
    end

    assign slot_value = {data_writeReg[WIDTH-1:SLOT_BITS], field_res};

    // Only CPU-owned registers forward; hardware registers and reg 0 show storage.
    assign wr_fwd    = ctrl_writeEnable && (ctrl_writeReg != '0) && !HW_MASK[ctrl_writeReg];
    assign fwd_value = wr_slot ? slot_value : data_writeReg;

    assign data_readRegA = (wr_fwd && ctrl_writeReg == ctrl_readRegA) ? fwd_value
                                                                       : regs[ctrl_readRegA];
    assign data_readRegB = (wr_fwd && ctrl_writeReg == ctrl_readRegB) ? fwd_value
                                                                       : regs[ctrl_readRegB];

    assign tap0 = regs[TAP0];
    assign tap1 = regs[TAP1];
    assign tap2 = regs[TAP2];

    // Register update: reset, then per-register hardware/CPU write policy.
    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            slot_fixup <= 1'b0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (i == 0) begin
                    regs[i] <= '0;
                end else if (HW_MASK[i] && STICKY_MASK[i]) begin
                    // Set wins over a same-cycle W1C on the same bit.
                    if (ctrl_writeEnable && ctrl_writeReg == ADDR_W'(i)) begin
                        regs[i] <= (regs[i] & ~data_writeReg) | hw_write[i*WIDTH +: WIDTH];
                    end else begin
                        regs[i] <= regs[i] | hw_write[i*WIDTH +: WIDTH];
                    end
                end else if (HW_MASK[i]) begin
                    regs[i] <= hw_write[i*WIDTH +: WIDTH];
                end else if (ctrl_writeEnable && ctrl_writeReg == ADDR_W'(i)) begin
                    if (i == SLOT_A || i == SLOT_B) begin
                        regs[i] <= slot_value;
                    end else begin
                        regs[i] <= data_writeReg;
                    end
                end
            end
            slot_fixup <= wr_slot && collide;
        end
    end

endmodule

// File: tb/tb_regfile_mmio.sv
// tb_regfile_mmio: directed stimulus with a behavioural register-file model
// checked every cycle, plus literal expectations at key points.
module tb_regfile_mmio;

    localparam logic [31:0] HWM = 32'h1CE;
    localparam logic [31:0] STM = 32'h00C;

    logic          clock = 1'b0;
    logic          ctrl_reset;
    logic          ctrl_writeEnable;
    logic [4:0]    ctrl_writeReg;
    logic [31:0]   data_writeReg;
    logic [4:0]    ctrl_readRegA;
    logic [4:0]    ctrl_readRegB;
    logic [31:0]   data_readRegA;
    logic [31:0]   data_readRegB;
    logic [1023:0] hw_write;
    logic [31:0]   tap0, tap1, tap2;
    logic          slot_fixup;

    int checks = 0;
    int errors = 0;
    bit started = 0;

    logic [31:0] mreg [32];
    logic        mfix;

    regfile_mmio dut (
        .clock(clock), .ctrl_reset(ctrl_reset), .ctrl_writeEnable(ctrl_writeEnable),
        .ctrl_writeReg(ctrl_writeReg), .data_writeReg(data_writeReg),
        .ctrl_readRegA(ctrl_readRegA), .ctrl_readRegB(ctrl_readRegB),
        .data_readRegA(data_readRegA), .data_readRegB(data_readRegB),
        .hw_write(hw_write), .tap0(tap0), .tap1(tap1), .tap2(tap2),
        .slot_fixup(slot_fixup)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Slot rule: out of range -> 0, differs from peer -> as asked, equal -> next mod 9.
    function automatic logic [31:0] slot_store(input int addr, input logic [31:0] d,
                                               output bit fix);
        int v, p, f;
        v = int'(d[3:0]);
        p = int'(mreg[(addr == 4) ? 5 : 4][3:0]);
        fix = 0;
        if (v >= 9) f = 0;
        else if (v != p) f = v;
        else begin
            f = (v + 1) % 9;
            fix = 1;
        end
        return {d[31:4], 4'(f)};
    endfunction

    function automatic logic [31:0] exp_read(input logic [4:0] ra);
        bit fx;
        if (ctrl_writeEnable && ctrl_writeReg == ra && ra != 0 && !HWM[ra]) begin
            if (ra == 4 || ra == 5) return slot_store(int'(ra), data_writeReg, fx);
            return data_writeReg;
        end
        return mreg[ra];
    endfunction

    // Model state advance at each rising edge.
    always @(posedge clock) begin
        logic [31:0] nm [32];
        logic [31:0] h;
        bit fx;
        bit nfix;
        nfix = 0;
        for (int i = 0; i < 32; i++) nm[i] = mreg[i];
        if (ctrl_reset) begin
            for (int i = 0; i < 32; i++) nm[i] = 0;
            started = 1;
        end else begin
            for (int i = 1; i < 32; i++) begin
                h = hw_write[i*32 +: 32];
                if (HWM[i] && STM[i]) begin
                    if (ctrl_writeEnable && int'(ctrl_writeReg) == i)
                        nm[i] = (mreg[i] & ~data_writeReg) | h;
                    else
                        nm[i] = mreg[i] | h;
                end else if (HWM[i]) begin
                    nm[i] = h;
                end else if (ctrl_writeEnable && int'(ctrl_writeReg) == i) begin
                    if (i == 4 || i == 5) begin
                        nm[i] = slot_store(i, data_writeReg, fx);
                        nfix = fx;
                    end else begin
                        nm[i] = data_writeReg;
                    end
                end
            end
        end
        for (int i = 0; i < 32; i++) mreg[i] = nm[i];
        mfix = nfix;
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clock) begin
        if (started) begin
            chk("cyc_readA", data_readRegA, exp_read(ctrl_readRegA));
            chk("cyc_readB", data_readRegB, exp_read(ctrl_readRegB));
            chk("cyc_tap0", tap0, mreg[4]);
            chk("cyc_tap1", tap1, mreg[5]);
            chk("cyc_tap2", tap2, mreg[9]);
            chk("cyc_fixup", {31'b0, slot_fixup}, {31'b0, mfix});
        end
    end

    task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [4:0] ra, input logic [4:0] rb);
        ctrl_writeEnable = we;
        ctrl_writeReg    = wa;
        data_writeReg    = wd;
        ctrl_readRegA    = ra;
        ctrl_readRegB    = rb;
        #1;
    endtask

    task automatic tick;
        @(posedge clock);
        #2;
    endtask

    task automatic set_hw(input int i, input logic [31:0] v);
        hw_write[i*32 +: 32] = v;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mreg[i] = 0;
        mfix = 0;
        hw_write = '0;
        ctrl_reset = 1'b1;
        drive(0, 0, 0, 12, 4);
        tick;
        tick;
        ctrl_reset = 1'b0;
        chk("rst_readA", data_readRegA, 32'h0);
        chk("rst_tap0", tap0, 32'h0);
        chk("rst_fixup", {31'b0, slot_fixup}, 32'h0);

        // General register write with forwarding, and reg 0.
        drive(1, 12, 32'hDEADBEEF, 12, 0);
        chk("fwd_gen", data_readRegA, 32'hDEADBEEF);
        tick;
        drive(0, 0, 0, 12, 0);
        chk("stored_gen", data_readRegA, 32'hDEADBEEF);
        chk("model_gen", mreg[12], 32'hDEADBEEF);
        drive(1, 0, 32'h5, 0, 12);
        chk("reg0_fwd", data_readRegA, 32'h0);
        tick;
        drive(0, 0, 0, 0, 12);
        chk("reg0_stored", data_readRegA, 32'h0);

        // Snapshot register.
        set_hw(6, 32'h1234);
        drive(0, 0, 0, 6, 0);
        tick;
        set_hw(6, 32'h0);
        drive(0, 0, 0, 6, 0);
        chk("snap_1", data_readRegA, 32'h1234);
        tick;
        chk("snap_0", data_readRegA, 32'h0);
        drive(1, 6, 32'hFFFF, 6, 0);
        chk("snap_nofwd", data_readRegA, 32'h0);
        tick;
        drive(0, 0, 0, 6, 0);
        chk("snap_cpu_ign", data_readRegA, 32'h0);

        // Sticky register.
        set_hw(2, 32'h1); drive(0, 0, 0, 2, 3); tick;
        set_hw(2, 32'h0); tick;
        set_hw(2, 32'h4); tick;
        set_hw(2, 32'h0); tick;
        chk("sticky_acc", data_readRegA, 32'h5);
        chk("model_sticky", mreg[2], 32'h5);
        drive(1, 2, 32'h1, 2, 3);
        chk("sticky_nofwd", data_readRegA, 32'h5);
        tick;
        drive(0, 0, 0, 2, 3);
        chk("sticky_w1c", data_readRegA, 32'h4);
        set_hw(2, 32'h4);
        drive(1, 2, 32'h4, 2, 3);
        tick;
        set_hw(2, 32'h0);
        drive(0, 0, 0, 2, 3);
        chk("sticky_set_wins", data_readRegA, 32'h4);

        // Slot registers.
        drive(1, 5, 32'h03, 4, 5);
        tick;
        drive(1, 4, 32'h30, 4, 5);
        chk("slot_a_fwd", data_readRegA, 32'h30);
        tick;
        drive(1, 5, 32'h70, 4, 5);
        chk("slot_b_fwd", data_readRegB, 32'h71);
        chk("slot_tap1_old", tap1, 32'h03);
        tick;
        drive(0, 0, 0, 4, 5);
        chk("slot_tap1", tap1, 32'h71);
        chk("slot_tap0", tap0, 32'h30);
        chk("slot_fixup1", {31'b0, slot_fixup}, 32'h1);
        chk("model_slot", mreg[5], 32'h71);
        tick;
        chk("slot_fixup0", {31'b0, slot_fixup}, 32'h0);
        drive(1, 5, 32'h08, 4, 5);
        tick;
        drive(1, 4, 32'h08, 4, 5);
        chk("slot_wrap_fwd", data_readRegA, 32'h00);
        tick;
        drive(0, 0, 0, 4, 5);
        chk("slot_wrap", tap0, 32'h00);
        chk("slot_wrap_fix", {31'b0, slot_fixup}, 32'h1);
        drive(1, 5, 32'h0F, 4, 5);
        tick;
        drive(0, 0, 0, 4, 5);
        chk("slot_range", tap1, 32'h00);
        chk("slot_range_fix", {31'b0, slot_fixup}, 32'h0);

        // Tap 2 from a general register.
        drive(1, 9, 32'hA5A5, 9, 0);
        chk("tap2_nofwd", tap2, 32'h0);
        tick;
        drive(0, 0, 0, 9, 0);
        chk("tap2", tap2, 32'hA5A5);

        // Reset during accumulation.
        set_hw(3, 32'hFF);
        set_hw(6, 32'h55);
        drive(0, 0, 0, 3, 12);
        tick;
        chk("pre_rst_sticky", data_readRegA, 32'hFF);
        drive(1, 5, 32'h71, 3, 12);
        tick;
        ctrl_reset = 1'b1;
        drive(1, 12, 32'h1111, 3, 12);
        tick;
        ctrl_reset = 1'b0;
        set_hw(3, 32'h0);
        set_hw(6, 32'h0);
        drive(0, 0, 0, 3, 12);
        chk("rst_sticky", data_readRegA, 32'h0);
        chk("rst_gen", data_readRegB, 32'h0);
        chk("rst_tap0b", tap0, 32'h0);
        chk("rst_tap1b", tap1, 32'h0);
        chk("rst_tap2b", tap2, 32'h0);
        chk("rst_fixupb", {31'b0, slot_fixup}, 32'h0);
        tick;
        tick;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
